// File: rtl/pwm_generator.sv
// Purpose: fixed-period PWM whose duty is stepped +/-1 by two debounced push buttons.
// Latency: button rise to duty update <= 2 + DEBOUNCE_DIV + 1 cycles; duty change seen on PWM_OUT one cycle later.
// Backpressure: none; free-running output, buttons are level inputs sampled continuously.
module pwm_generator #(
    parameter int PERIOD       = 10,
    parameter int DUTY_RESET   = 5,
    parameter int DEBOUNCE_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic increase_duty,
    input  logic decrease_duty,
    output logic PWM_OUT
);

    // Counter and duty share one width so the output compare needs no padding.
    localparam int W     = $clog2(PERIOD + 1);
    localparam int DIV_W = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;

    localparam logic [W-1:0]     CNT_LAST  = W'(PERIOD - 1);
    localparam logic [W-1:0]     DUTY_MAX  = W'(PERIOD);
    localparam logic [W-1:0]     DUTY_INIT = W'(DUTY_RESET);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DEBOUNCE_DIV - 1);

    // Bit 0 = increase button, bit 1 = decrease button.
    logic [1:0] btn;
    logic [1:0] sync1_q, sync2_q;
    logic [1:0] db0_q, db1_q;
    logic [1:0] ev_q, ev_d;

    logic [DIV_W-1:0] div_q, div_d;
    logic             en;

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] duty_q, duty_d;
    logic         pwm_q, pwm_d;

    assign btn = {decrease_duty, increase_duty};

    // Two-flop synchronizer for both buttons.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

    // Sample-enable divider: en fires on the last count of each DEBOUNCE_DIV window.
    always_comb begin
        en    = (div_q == DIV_LAST);
        div_d = en ? '0 : div_q + DIV_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) div_q <= '0;
        else     div_q <= div_d;
    end

    // Event when the newly sampled value is high and the previous sample was low.
    always_comb begin
        ev_d = en ? (sync2_q & ~db0_q) : 2'b00;
    end

    // Debounce sample shift and registered one-cycle press events.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db0_q <= '0;
            db1_q <= '0;
            ev_q  <= '0;
        end else begin
            if (en) begin
                db0_q <= sync2_q;
                db1_q <= db0_q;
            end
            ev_q <= ev_d;
        end
    end

    // Saturating duty update; simultaneous events cancel.
    always_comb begin
        duty_d = duty_q;
        if (ev_q[0] && !ev_q[1] && (duty_q < DUTY_MAX))
            duty_d = duty_q + W'(1);
        else if (ev_q[1] && !ev_q[0] && (duty_q != '0))
            duty_d = duty_q - W'(1);
    end

    // Free-running period counter and the output compare.
    always_comb begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + W'(1);
        pwm_d = (cnt_q < duty_q);
    end

    // Duty, period counter and registered PWM output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_q <= DUTY_INIT;
            cnt_q  <= '0;
            pwm_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            cnt_q  <= cnt_d;
            pwm_q  <= pwm_d;
        end
    end

    assign PWM_OUT = pwm_q;

endmodule

// File: tb/tb_pwm_generator.sv
// Purpose: randomized self-checking bench for pwm_generator against a duty/phase reference model.
// Latency: model expects PWM_OUT after the n-th edge since reset release = ((n-1) mod 10) < duty.
// Backpressure: none; buttons are driven as timed pulses with long settle gaps.
module tb_pwm_generator;

    localparam int PERIOD = 10;

    logic clk;
    logic rst;
    logic increase_duty;
    logic decrease_duty;
    logic PWM_OUT;

    int n_cmp;
    int n_bad;
    int model_duty;
    int cyc;

    pwm_generator dut (
        .clk           (clk),
        .rst           (rst),
        .increase_duty (increase_duty),
        .decrease_duty (decrease_duty),
        .PWM_OUT       (PWM_OUT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges elapsed since reset release; defines the expected PWM phase.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Expected output after the cyc-th edge for a given duty.
    function automatic logic exp_pwm(input int n, input int duty);
        if (n < 1) return 1'b0;
        return (((n - 1) % PERIOD) < duty);
    endfunction

    // Compare ten consecutive output samples against the model as one comparison.
    task automatic check_window(input string name);
        logic [PERIOD-1:0] obs;
        logic [PERIOD-1:0] exp;
        for (int i = 0; i < PERIOD; i++) begin
            @(negedge clk);
            obs[i] = PWM_OUT;
            exp[i] = exp_pwm(cyc, model_duty);
        end
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed pattern %b, required %b (duty %0d)", name, obs, exp, model_duty);
        end
    endtask

    // Apply one press (either/both buttons) for len cycles, then let it settle.
    task automatic press(input logic inc, input logic dec, input int len);
        @(posedge clk); #1;
        increase_duty = inc;
        decrease_duty = dec;
        repeat (len) @(posedge clk);
        #1;
        increase_duty = 1'b0;
        decrease_duty = 1'b0;
        repeat (12) @(posedge clk);
        if (inc && !dec && model_duty < PERIOD) model_duty++;
        else if (dec && !inc && model_duty > 0) model_duty--;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        increase_duty = 1'b0;
        decrease_duty = 1'b0;
        #1;
        n_cmp++;
        if (PWM_OUT !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_out: observed %b, required 0", PWM_OUT);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_duty = 5;
    endtask

    task automatic test_reset();
        do_reset();
        // First high sample lands right after the first edge after release.
        @(negedge clk);
        n_cmp++;
        if (PWM_OUT !== 1'b1) begin
            n_bad++;
            $display("FAIL first_high: observed %b, required 1", PWM_OUT);
        end
        // Idle roughly 100 cycles of 5/10 waveform.
        for (int w = 0; w < 10; w++) check_window("idle_50pct");
    endtask

    task automatic test_steps();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            press(1'b1, 1'b0, 10);
            check_window("inc_step");
        end
        for (int k = 0; k < 3; k++) begin
            press(1'b0, 1'b1, 10);
            check_window("dec_step");
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < 7; k++) press(1'b1, 1'b0, 8);
        check_window("sat_high");
        for (int k = 0; k < 12; k++) press(1'b0, 1'b1, 8);
        check_window("sat_low");
    endtask

    task automatic test_hold_and_both();
        do_reset();
        press(1'b1, 1'b0, 200);
        check_window("hold_one_step");
        do_reset();
        press(1'b1, 1'b1, 10);
        check_window("both_no_change");
        // A short glitch may or may not register: accept duty 5 or 6.
        press(1'b1, 1'b0, 2);
        begin
            int highs;
            highs = 0;
            for (int i = 0; i < PERIOD; i++) begin
                @(negedge clk);
                highs += int'(PWM_OUT);
            end
            n_cmp++;
            if (highs != 5 && highs != 6) begin
                n_bad++;
                $display("FAIL short_pulse: observed %0d high cycles, required 5 or 6", highs);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int k = 0; k < 3; k++) press(1'b1, 1'b0, 10);
        check_window("pre_reset_duty8");
        // Land mid-cycle where the output is high (cnt 0..7 of 10).
        while (!(exp_pwm(cyc + 1, 8) && (cyc % PERIOD) > 2)) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (PWM_OUT !== 1'b0 || dut.cnt_q !== '0) begin
            n_bad++;
            $display("FAIL async_reset: observed out %b cnt %0d, required out 0 cnt 0", PWM_OUT, dut.cnt_q);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_duty = 5;
        check_window("post_reset_50pct");
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 30; k++) begin
            int op;
            int len;
            op  = $urandom_range(2, 0);
            len = $urandom_range(15, 6);
            press(op == 0 || op == 2, op == 1 || op == 2, len);
            check_window("random_press");
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        model_duty = 5;
        rst = 1'b1;
        increase_duty = 1'b0;
        decrease_duty = 1'b0;
        test_reset();
        test_steps();
        test_saturation();
        test_hold_and_both();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
